// File: rtl/vbs_scanout.sv
// rtl/vbs_scanout.sv - PAL-style 1bpp scanout engine with CPU/video RAM arbitration
//
// Purpose: generates the composite sync and the serial pixel stream for a
// configurable raster, fetching one byte every 8 clocks from a byte-wide
// synchronous RAM. CPU accesses share the RAM port. Video fetches always win,
// and a colliding CPU access is delayed by one clock.
//
// Ports:
//   clk, reset             pixel clock, asynchronous active-high reset
//   baseAddr               frame start address, captured at the end of line V_START-1
//   invert                 inverts active pixels (border stays black)
//   sync, pixel            composite sync (low = tip), video data (1 = white)
//   frameStart             one-clock pulse while hCounter=0, vCounter=0
//   cAddr, cDataIn         CPU address / write data
//   cStrobe, cWrite        CPU request (held until cReady), 1 = write
//   cReady, cDataOut       one-clock completion pulse, read data during cReady
//   mAddr, mDataOut        RAM address / write data
//   mStrobe, mWrite        RAM access enable / write enable
//   mDataIn                RAM read data, one clock after the access

module vbs_scanout #(
    parameter int H_TOTAL      = 512,
    parameter int V_TOTAL      = 313,
    parameter int HSYNC_LEN    = 29,
    parameter int VSYNC_LINES  = 3,
    parameter int H_START      = 96,
    parameter int V_START      = 35,
    parameter int ACTIVE_BYTES = 40,
    parameter int ACTIVE_LINES = 192,
    parameter int LINE_REPEAT  = 1,
    parameter int STRIDE       = 40,
    parameter int ADDR_WIDTH   = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic                  invert,
    output logic                  sync,
    output logic                  pixel,
    output logic                  frameStart,
    input  logic [ADDR_WIDTH-1:0] cAddr,
    input  logic [7:0]            cDataIn,
    input  logic                  cStrobe,
    input  logic                  cWrite,
    output logic                  cReady,
    output logic [7:0]            cDataOut,
    output logic [ADDR_WIDTH-1:0] mAddr,
    output logic [7:0]            mDataOut,
    output logic                  mStrobe,
    output logic                  mWrite,
    input  logic [7:0]            mDataIn
);
    localparam int HW          = $clog2(H_TOTAL);
    localparam int VW          = $clog2(V_TOTAL);
    localparam int FETCH_FIRST = H_START - 2;
    localparam int WIN_END     = H_START + 8 * ACTIVE_BYTES;
    localparam int V_END       = V_START + ACTIVE_LINES;

    typedef enum logic [1:0] {
        C_IDLE,
        C_WAIT,
        C_ISSUE,
        C_DONE
    } cpuState_t;

    cpuState_t state, stateNext;

    logic [HW-1:0]         hCounter, hNext;
    logic [VW-1:0]         vCounter, vNext;
    logic                  lineEnd;
    logic [31:0]           h32, v32, hN32, vN32, hOff;
    logic                  curActive, nextActive, nextIsVideo, nextInWin, syncNext;
    logic [ADDR_WIDTH-1:0] lineAddr, fetchAddr;
    logic [1:0]            repeatCnt;
    logic [7:0]            shiftReg;
    logic                  videoSlot, loadSlot, pixelWin;

    logic                  mStrobeNext, mWriteNext;
    logic [ADDR_WIDTH-1:0] mAddrNext;
    logic [7:0]            mDataOutNext;

    // Counter values for the coming clock; registered outputs are computed
    // from these so they line up with the counters they belong to.
    assign lineEnd = (hCounter == HW'(H_TOTAL - 1));
    assign hNext   = lineEnd ? '0 : hCounter + 1'b1;
    assign vNext   = !lineEnd ? vCounter :
                     (vCounter == VW'(V_TOTAL - 1)) ? '0 : vCounter + 1'b1;

    assign h32  = 32'(hCounter);
    assign v32  = 32'(vCounter);
    assign hN32 = 32'(hNext);
    assign vN32 = 32'(vNext);

    assign curActive  = (v32 >= 32'(V_START)) && (v32 < 32'(V_END));
    assign nextActive = (vN32 >= 32'(V_START)) && (vN32 < 32'(V_END));

    // Below FETCH_FIRST the subtraction wraps to a huge value and fails the range test.
    assign hOff        = hN32 - 32'(FETCH_FIRST);
    assign nextIsVideo = nextActive && (hOff < 32'(8 * ACTIVE_BYTES)) && (hOff[2:0] == 3'd0);
    assign fetchAddr   = lineAddr + ADDR_WIDTH'(hOff >> 3);
    assign nextInWin   = nextActive && (hN32 >= 32'(H_START)) && (hN32 < 32'(WIN_END));

    always_comb begin
        syncNext = 1'b1;
        if (vN32 < 32'(VSYNC_LINES)) begin
            if ((hN32 >= 32'd1) && (hN32 < 32'(H_TOTAL - HSYNC_LEN)))
                syncNext = 1'b0;
        end else begin
            if ((hN32 >= 32'd1) && (hN32 < 32'(1 + HSYNC_LEN)))
                syncNext = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hCounter   <= '0;
            vCounter   <= '0;
            sync       <= 1'b1;
            frameStart <= 1'b0;
            pixelWin   <= 1'b0;
            videoSlot  <= 1'b0;
            loadSlot   <= 1'b0;
            shiftReg   <= 8'hFF;
            lineAddr   <= '0;
            repeatCnt  <= 2'd0;
        end else begin
            hCounter   <= hNext;
            vCounter   <= vNext;
            sync       <= syncNext;
            frameStart <= (hN32 == 32'd0) && (vN32 == 32'd0);
            pixelWin   <= nextInWin;
            videoSlot  <= nextIsVideo;
            // RAM data arrives one clock after the fetch slot.
            loadSlot   <= videoSlot;
            shiftReg   <= loadSlot ? mDataIn : {shiftReg[6:0], 1'b1};
            if (lineEnd) begin
                if (v32 == 32'(V_START - 1)) begin
                    lineAddr  <= baseAddr;
                    repeatCnt <= 2'd0;
                end else if (curActive) begin
                    if (repeatCnt == 2'(LINE_REPEAT - 1)) begin
                        repeatCnt <= 2'd0;
                        lineAddr  <= lineAddr + ADDR_WIDTH'(STRIDE);
                    end else begin
                        repeatCnt <= repeatCnt + 2'd1;
                    end
                end
            end
        end
    end

    // RAM bit 1 is black; the border is forced black regardless of invert.
    assign pixel = pixelWin & (~shiftReg[7] ^ invert);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= C_IDLE;
            mStrobe  <= 1'b0;
            mWrite   <= 1'b0;
            mAddr    <= '0;
            mDataOut <= 8'h00;
        end else begin
            state    <= stateNext;
            mStrobe  <= mStrobeNext;
            mWrite   <= mWriteNext;
            mAddr    <= mAddrNext;
            mDataOut <= mDataOutNext;
        end
    end

    // The RAM port for the next clock is decided here: a video slot takes it,
    // otherwise a CPU access entering C_ISSUE does. C_DONE ignores cStrobe so
    // a request still held during cReady is not taken twice.
    always_comb begin
        stateNext    = state;
        mStrobeNext  = 1'b0;
        mWriteNext   = 1'b0;
        mAddrNext    = mAddr;
        mDataOutNext = mDataOut;
        case (state)
            C_IDLE:  if (cStrobe) stateNext = nextIsVideo ? C_WAIT : C_ISSUE;
            C_WAIT:  stateNext = nextIsVideo ? C_WAIT : C_ISSUE;
            C_ISSUE: stateNext = C_DONE;
            C_DONE:  stateNext = C_IDLE;
            default: stateNext = C_IDLE;
        endcase
        if (nextIsVideo) begin
            mStrobeNext = 1'b1;
            mAddrNext   = fetchAddr;
        end else if (stateNext == C_ISSUE) begin
            mStrobeNext  = 1'b1;
            mWriteNext   = cWrite;
            mAddrNext    = cAddr;
            mDataOutNext = cDataIn;
        end
    end

    assign cReady   = (state == C_DONE);
    assign cDataOut = cReady ? mDataIn : 8'h00;

endmodule

// File: doc/vbs_scanout.md
# vbs_scanout

Parametrised composite-video scanout engine: generates the sync signal and serial 1-bit-per-pixel stream for a PAL-style raster from a byte-wide video RAM, and arbitrates CPU access to that RAM with a ready handshake. Successor of the fixed 320x192 generator: timing, active window, line stride, line repeat, base address and inversion are configurable. Sits between the CPU bus decoder and the external synchronous RAM; output feeds the video DAC/mixer.

## Interface
Parameters:
- H_TOTAL, 512, clocks per line (8 MHz -> 64 us)
- V_TOTAL, 313, lines per frame
- HSYNC_LEN, 29, sync-low clocks on normal lines
- VSYNC_LINES, 3, broad-pulse lines at frame start (lines 0..VSYNC_LINES-1)
- H_START, 96, hCounter value where first active pixel appears
- V_START, 35, first active line
- ACTIVE_BYTES, 40, bytes fetched per active line
- ACTIVE_LINES, 192, displayed lines (after repeat)
- LINE_REPEAT, 1, each RAM line shown this many times (1..4)
- STRIDE, 40, address step between RAM lines (>= ACTIVE_BYTES)
- ADDR_WIDTH, 13, RAM address width

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- baseAddr  in  ADDR_WIDTH  frame start address, sampled once per frame
- invert  in  1  inverts active pixels
- sync  out  1  composite sync, low = sync tip
- pixel  out  1  video data, 1 = white
- frameStart  out  1  one-clock pulse at line 0, hCounter 0
- cAddr  in  ADDR_WIDTH  CPU address
- cDataIn  in  8  CPU write data
- cStrobe  in  1  CPU request, held until cReady
- cWrite  in  1  1 = write
- cReady  out  1  one-clock completion pulse
- cDataOut  out  8  read data, valid while cReady=1
- mAddr  out  ADDR_WIDTH  RAM address
- mDataOut  out  8  RAM write data
- mStrobe  out  1  RAM access enable
- mWrite  out  1  RAM write enable
- mDataIn  in  8  RAM read data, one-clock latency

## Operation
- hCounter 0..H_TOTAL-1, vCounter 0..V_TOTAL-1, both wrap to 0; vCounter advances when hCounter wraps.
- sync (registered): normal line low for hCounter in [1, 1+HSYNC_LEN); lines < VSYNC_LINES low for [1, H_TOTAL-HSYNC_LEN); high otherwise.
- Active line: vCounter in [V_START, V_START+ACTIVE_LINES). At end of line V_START-1, lineAddr <= baseAddr, repeatCnt <= 0.
- Active line fetch: byte k (0..ACTIVE_BYTES-1) fetched at hCounter H_START-2+8k (video slot), data loaded into shift register at H_START-1+8k, MSB shown first.
- After each active line: repeatCnt increments; at LINE_REPEAT-1 it clears and lineAddr += STRIDE (mod 2^ADDR_WIDTH).
- Pixel: RAM bit 1 = black. pixel = ~shiftReg[7] ^ invert inside the window [H_START, H_START+8*ACTIVE_BYTES) of active lines; 0 elsewhere (invert not applied to border).
- Arbitration: video slot has absolute priority. A pending CPU request is issued on any non-video cycle: mAddr=cAddr, mStrobe=1, mWrite=cWrite, mDataOut=cDataIn. cReady pulses the following clock; cDataOut=mDataIn at that clock.
- One CPU access in flight; cStrobe sampled again only after cReady. Request stalled by a video slot waits exactly one clock.
- mStrobe=0 on idle cycles.

## Timing
- Reset values: hCounter=vCounter=0, sync=1, pixel=0, frameStart=0, cReady=0, cDataOut=0, mStrobe=0, mWrite=0, shift register all 1s, lineAddr=0.
- Reset mid-line or mid-access: in-flight CPU access dropped, no cReady; CPU must keep cStrobe asserted and is served after release.
- CPU latency: 2 clocks from cStrobe sample to cReady when not colliding, 3 when colliding with a video slot.
- Write during a line being displayed: a write to an address not yet fetched is visible on this line; no coherence beyond that.
- baseAddr change mid-frame has no effect until the next frame.
- frameStart coincides with hCounter=0, vCounter=0.

## Test plan
- Defaults, after reset: sync low for hCounter 1..29 on line 10; lines 0..2 low for 1..482; frameStart period 160256 clocks.
- RAM byte 0 = 0x0F, baseAddr=0: line 35 pixel = 1,1,1,1,0,0,0,0 at hCounter 96..103; pixel 0 at 95 and 416.
- invert=1, same data: pixel = 0,0,0,0,1,1,1,1 at 96..103; border still 0.
- LINE_REPEAT=2, STRIDE=48, baseAddr=0x100: lines 35,36 fetch from 0x100, lines 37,38 from 0x130.
- CPU read of 0x0123 (contains 0xA5) issued at hCounter 94 of line 35 (video slot): mStrobe with mAddr=0x0123 at 95, cReady with cDataOut=0xA5 at 96.
- CPU write 0x55 to 0x0005 during line 35 before byte 5 fetch: byte 5 pixels on that line show 0x55 pattern; reset asserted during a write yields no cReady.
